// File: rtl/imem_loader_pkg.sv
// Shared sizes and address helper for the instruction-memory loader.
// ISIZE is the instruction/address width used by the fetch path.
package imem_loader_pkg;

   localparam int ISIZE        = 32;
   localparam int LOADER_DEPTH = 256;

   function automatic logic [ISIZE-1:0] word_addr(
      input logic [ISIZE-1:0] base,
      input logic [ISIZE-1:0] idx,
      input logic [ISIZE-1:0] step
   );
      return base + idx * step;
   endfunction

endpackage

// File: rtl/imem_loader_wr_reg.sv
// Registered write port toward the instruction memory.
// Address and data hold their last value between writes.
module imem_loader_wr_reg
   import imem_loader_pkg::*;
#(
   parameter logic [ISIZE-1:0] BASE_ADDR = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic [ISIZE-1:0] addr_i,
   input  logic [ISIZE-1:0] data_i,
   output logic             wen_o,
   output logic [ISIZE-1:0] addr_o,
   output logic [ISIZE-1:0] data_o
);

   logic             wen_q;
   logic [ISIZE-1:0] addr_q;
   logic [ISIZE-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wen_q  <= 1'b0;
         addr_q <= BASE_ADDR;
         data_q <= '0;
      end else begin
         wen_q <= wr_i;
         if (wr_i) begin
            addr_q <= addr_i;
            data_q <= data_i;
         end
      end
   end

   assign wen_o  = wen_q;
   assign addr_o = addr_q;
   assign data_o = data_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory and holds the
// core in reset until the whole image has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned      DEPTH     = LOADER_DEPTH,
   parameter logic [ISIZE-1:0] BASE_ADDR = '0,
   parameter logic [ISIZE-1:0] ADDR_STEP = ISIZE'(1),
   parameter int unsigned      CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [ISIZE-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             mem_wen,
   output logic [ISIZE-1:0] mem_addr,
   output logic [ISIZE-1:0] mem_data,
   output logic             cpu_rst,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] word_count
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_FLUSH = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERR   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_LOAD  = ST_LOAD,
      S_FLUSH = ST_FLUSH,
      S_DONE  = ST_DONE,
      S_ERR   = ST_ERR
   } ld_state_e;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

   ld_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, cpu_rst_q, err_q;
   logic             accept;
   logic [ISIZE-1:0] wr_addr;

   assign in_ready = (state_q == S_LOAD);
   assign accept   = in_valid & in_ready;
   assign wr_addr  = word_addr(BASE_ADDR, ISIZE'(cnt_q), ADDR_STEP);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (in_last) begin
                  state_d = S_FLUSH;
               end else if (cnt_q == LAST_IDX) begin
                  state_d = S_ERR;
               end
            end
         end
         S_FLUSH: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status flags are registered from the next state so they
   // change on the same edge as the state itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         cpu_rst_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         done_q    <= (state_d == S_DONE);
         cpu_rst_q <= (state_d != S_DONE);
         err_q     <= (state_d == S_ERR);
      end
   end

   imem_loader_wr_reg #(
      .BASE_ADDR(BASE_ADDR)
   ) u_wr_reg (
      .clk   (clk),
      .rst   (rst),
      .wr_i  (accept),
      .addr_i(wr_addr),
      .data_i(in_data),
      .wen_o (mem_wen),
      .addr_o(mem_addr),
      .data_o(mem_data)
   );

   assign cpu_rst    = cpu_rst_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_count = cnt_q;

endmodule
